// File: rtl/bin_to_ascii_conv.sv
// Sequential double-dabble binary to decimal ASCII converter, MSD first.
// Define LEAD_ZERO_BLANK_EN to print leading zero digits as spaces.
module bin_to_ascii_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   input  logic                  ack_i,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [8*DIGITS-1:0]   ascii_o
);

   localparam int BW = 4 * DIGITS;
   localparam int AW = 8 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FORMAT,
      VALID
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [BW-1:0]    bcd_adj;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    ascii_q, ascii_d;
   logic             load;

   // Add 3 to every BCD nibble that would overflow past 9 when doubled.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Map BCD nibbles to ASCII; optionally blank zeros above the first nonzero.
   function automatic logic [AW-1:0] to_ascii(input logic [BW-1:0] b);
      logic [AW-1:0] a;
`ifdef LEAD_ZERO_BLANK_EN
      logic          lead;
      lead = 1'b1;
`endif
      a = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         a[8*i +: 8] = 8'h30 + {4'h0, b[4*i +: 4]};
`ifdef LEAD_ZERO_BLANK_EN
         if (lead && (i > 0) && (b[4*i +: 4] == 4'h0)) begin
            a[8*i +: 8] = 8'h20;
         end else begin
            lead = 1'b0;
         end
`endif
      end
      return a;
   endfunction

   // Next-state and datapath: one shift per SHIFT cycle, ASCII latched in FORMAT.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ascii_d = ascii_q;
      load    = 1'b0;
      bcd_adj = add3(bcd_q);
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               load = 1'b1;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = FORMAT;
            end
         end
         FORMAT: begin
            ascii_d = to_ascii(bcd_q);
            state_d = VALID;
         end
         VALID: begin
            if (start_i) begin
               load = 1'b1;
            end else if (ack_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (load) begin
         bin_d   = bin_i;
         bcd_d   = '0;
         cnt_d   = CW'(WIDTH - 1);
         state_d = SHIFT;
      end
   end

   // State and datapath registers; reset shows a blank display.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ascii_q <= {DIGITS{8'h20}};
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ascii_q <= ascii_d;
      end
   end

   assign busy_o  = (state_q == SHIFT) || (state_q == FORMAT);
   assign valid_o = (state_q == VALID);
   assign ascii_o = ascii_q;

endmodule

// File: tb/tb_bin_to_ascii_conv.sv
// Randomized self-checking bench for bin_to_ascii_conv.
// Honours LEAD_ZERO_BLANK_EN in its reference model.
module tb_bin_to_ascii_conv;

   localparam int W = 16;
   localparam int D = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_i = 1'b0;
   logic [W-1:0]  bin_i = '0;
   logic          ack_i = 1'b0;
   logic          busy_o;
   logic          valid_o;
   logic [8*D-1:0] ascii_o;

   int errors = 0;
   int checks = 0;

   bin_to_ascii_conv #(.WIDTH(W), .DIGITS(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .bin_i   (bin_i),
      .ack_i   (ack_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .ascii_o (ascii_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [8*D-1:0] model(input int v);
      logic [8*D-1:0] s;
      int p;
      s = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         s[8*i +: 8] = 8'(48 + (v / p) % 10);
`ifdef LEAD_ZERO_BLANK_EN
         if (i > 0 && v < p) s[8*i +: 8] = 8'h20;
`endif
         p = p * 10;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int v);
      start_i = 1'b1;
      bin_i   = W'(v);
      tick();
      start_i = 1'b0;
      bin_i   = W'($urandom);
   endtask

   task automatic wait_valid(output int n, output int nb);
      n  = 0;
      nb = 0;
      while (!valid_o && n < 40) begin
         if (busy_o) nb++;
         tick();
         n++;
      end
   endtask

   task automatic do_ack;
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
   endtask

   int n, nb, v, pulses, dbl, chg;
   int pidx[4];
   logic prev_v;
   logic [8*D-1:0] prev_a;

   initial begin
      tick();
      tick();
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_ascii", ascii_o, {D{8'h20}});
      rst = 1'b1;
      tick();

      do_start(256);
      wait_valid(n, nb);
      chk("t1_lat", n, 17);
      chk("t1_busy", nb, 17);
      chk("t1_ascii", ascii_o, model(256));
      do_ack();

      do_start(0);
      wait_valid(n, nb);
      chk("t2_zero", ascii_o, model(0));
      do_ack();
      chk("t2_ackv", valid_o, 0);
      chk("t2_hold", ascii_o, model(0));
      do_start(65535);
      wait_valid(n, nb);
      chk("t2_max", ascii_o, model(65535));
      do_ack();
      chk("t2_ackv2", valid_o, 0);

      do_start(4242);
      repeat (4) tick();
      start_i = 1'b1;
      bin_i   = 16'd9;
      chk("t3_old", ascii_o, model(65535));
      tick();
      start_i = 1'b0;
      bin_i   = 16'd1;
      wait_valid(n, nb);
      chk("t3_lat", n, 12);
      chk("t3_ascii", ascii_o, model(4242));
      do_ack();

      do_start(777);
      repeat (7) tick();
      rst = 1'b0;
      #1;
      chk("t4_busy", busy_o, 0);
      chk("t4_valid", valid_o, 0);
      chk("t4_ascii", ascii_o, {D{8'h20}});
      tick();
      rst = 1'b1;
      repeat (20) tick();
      chk("t4_novalid", valid_o, 0);
      do_start(81);
      wait_valid(n, nb);
      chk("t4_81", ascii_o, model(81));

      start_i = 1'b1;
      ack_i   = 1'b1;
      bin_i   = 16'd1024;
      tick();
      start_i = 1'b0;
      ack_i   = 1'b0;
      wait_valid(n, nb);
      chk("t5_low", n, 17);
      chk("t5_ascii", ascii_o, model(1024));
      do_ack();

      start_i = 1'b1;
      bin_i   = 16'd81;
      pulses  = 0;
      dbl     = 0;
      chg     = 0;
      prev_v  = valid_o;
      prev_a  = ascii_o;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (valid_o) begin
            if (pulses < 4) pidx[pulses] = i;
            pulses++;
            if (prev_v) dbl++;
         end
         if (ascii_o !== prev_a) chg++;
         prev_v = valid_o;
         prev_a = ascii_o;
      end
      start_i = 1'b0;
      chk("t6_pulses", pulses, 4);
      chk("t6_width", dbl, 0);
      chk("t6_first", pidx[0], 17);
      chk("t6_per1", pidx[1] - pidx[0], 18);
      chk("t6_per2", pidx[2] - pidx[1], 18);
      chk("t6_stable", chg, 1);
      chk("t6_ascii", ascii_o, model(81));
      wait_valid(n, nb);
      do_ack();

      for (int k = 0; k < 24; k++) begin
         case (k % 6)
            0: v = 0;
            1: v = 65535;
            default: v = int'($urandom_range(0, 65535));
         endcase
         do_start(v);
         ack_i = 1'($urandom);
         wait_valid(n, nb);
         ack_i = 1'b0;
         chk("rnd_lat", n, 17);
         chk("rnd_ascii", ascii_o, model(v));
         do_ack();
         chk("rnd_ack", valid_o, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
